jk_bank_arbiter: RTL
====================

Name: jk_bank_arbiter

Overview:
Shares one bank of WIDTH JK flip-flops between NREQ requesters. Each requester posts a JK command (hold/reset/set/toggle) with a bit mask. A round-robin arbiter grants one command at a time. A small FSM drives the bank's J/K/en lines for exactly one cycle and then returns a one-cycle acknowledge. It sits between the control logic in sequential_ckt and the JK storage cells.

Parameters:
WIDTH, 8, number of JK cells in the bank (1..32)
NREQ, 4, number of requesters (2..8)
IDXW, $clog2(NREQ), width of the grant index

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  NREQ  requester i has a pending command
req_op  in  2*NREQ  op for requester i at bits [2i+1:2i]: 00 hold, 01 reset (J=0,K=1), 10 set (J=1,K=0), 11 toggle (J=1,K=1)
req_mask  in  WIDTH*NREQ  cells affected by requester i at bits [WIDTH*i +: WIDTH]
req_ack  out  NREQ  one-hot, one-cycle pulse: the command has completed
q  out  WIDTH  current bank state
busy  out  1  high whenever the FSM is not IDLE
grant_idx  out  IDXW  index of the last granted requester

Behaviour:
- Reset (asynchronous, active-high rst): q=0, req_ack=0, busy=0, grant_idx=0, state=IDLE, round-robin pointer=0 (requester 0 has highest priority). Reset mid-operation aborts the command, issues no ack, and leaves q=0.
- FSM states:
  - IDLE: if any req_valid is set, pick a winner by round-robin starting at the pointer. Latch the winner's op and mask, set grant_idx, go to APPLY. Otherwise stay in IDLE.
  - APPLY: the cell enable equals the latched mask, and J/K come from the latched op for all cells. Masked cells update at the end of this cycle per the JK truth table: 00 hold, 01 ->0, 10 ->1, 11 ->~q. Unmasked cells hold. Go to DONE.
  - DONE: req_ack[grant_idx]=1 for this cycle only. The pointer becomes (grant_idx+1) mod NREQ. Go to IDLE.
- Latency: for a request seen in IDLE at cycle t, q is updated and visible at t+2, req_ack pulses during t+2, and the next grant is possible at t+3. Throughput is one command per 3 cycles.
- Handshake:
  - The requester holds valid, op and mask until it sees ack high.
  - It must drop valid (or present a new command) in the cycle after ack.
  - op and mask are sampled only in IDLE. Changes made after the grant are ignored.
  - If valid drops after the grant, the command still completes and the ack still fires.
- busy=1 in APPLY and DONE.
- Round-robin: with all requesters continuously valid, grants go 0,1,2,3,0,...; no requester waits more than NREQ grants.
  - The pointer wraps from NREQ-1 to 0.
  - A non-power-of-two NREQ must wrap correctly, never granting an index >= NREQ.
- Edge cases:
  - Op 00 or mask 0 completes normally (full 3-cycle sequence, ack) with q unchanged.
  - A requester whose valid stays high after its ack is re-arbitrated; it gets lowest priority for the next grant.

Decomposition:
- Package jk_pkg holds:
  - op encodings OP_HOLD=2'b00, OP_RST=2'b01, OP_SET=2'b10, OP_TGL=2'b11;
  - FSM state encoding IDLE/APPLY/DONE;
  - function op_to_jk returning {J,K}.
- Sub-module jk_cell: one JK flip-flop with enable, clk, and async active-high rst. Ports clk, rst, en, J, K, Q. It is instantiated WIDTH times in a generate loop.
- The arbiter and FSM live in jk_bank_arbiter.

Test Plan:
1. Assert rst mid-APPLY after a set with mask 8'hFF -> q=8'h00 immediately; no ack; busy=0; the next request from requester 0 is granted first.
2. Requester 1 only: set, mask 8'h0F, at cycle t -> busy=1 at t+1; q=8'h0F and req_ack=4'b0010 at t+2; IDLE at t+3.
3. From q=8'h0F, requester 2 toggles mask 8'hFF, then requester 3 resets mask 8'h01 -> q=8'hF0, then q=8'hF0 (bit 0 already 0); one ack each.
4. All four valid continuously with hold ops -> grant_idx sequence 0,1,2,3,0,1; acks 3 cycles apart; q unchanged.
5. Requester 0 drops valid the cycle after its grant (op set, mask 8'h80) -> q[7]=1 and req_ack[0] still pulses.
6. NREQ=3 build, all valid -> grant_idx sequence 0,1,2,0,1,2; never 3.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared encodings for the JK bank arbiter: command ops, FSM states and
// the op -> {J,K} mapping used to drive the storage cells.
package jk_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_RST  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_TGL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [1:0] op_to_jk(input logic [1:0] op);
    logic [1:0] jk;
    case (op)
      OP_RST:  jk = 2'b01;
      OP_SET:  jk = 2'b10;
      OP_TGL:  jk = 2'b11;
      default: jk = 2'b00;
    endcase
    return jk;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with clock enable and asynchronous active-high reset.
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic J,
  input  logic K,
  output logic Q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Q <= 1'b0;
    end else if (en) begin
      case ({J, K})
        2'b01:   Q <= 1'b0;
        2'b10:   Q <= 1'b1;
        2'b11:   Q <= ~Q;
        default: Q <= Q;
      endcase
    end
  end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sharing one bank of WIDTH JK cells between NREQ
// requesters; each granted command runs IDLE -> APPLY -> DONE (ack).
module jk_bank_arbiter
  import jk_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDXW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [2*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_mask,
  output logic [NREQ-1:0]       req_ack,
  output logic [WIDTH-1:0]      q,
  output logic                  busy,
  output logic [IDXW-1:0]       grant_idx
);

  state_t r_state, w_next;

  logic [IDXW-1:0]                r_ptr;
  logic [IDXW-1:0]                r_grant;
  logic [1:0]                     r_op;
  logic [WIDTH-1:0]               r_mask;
  logic [IDXW-1:0]                w_win;
  logic                           w_any;
  logic [IDXW:0]                  w_sum;
  logic [1:0]                     w_jk;
  logic [WIDTH-1:0]               w_en;
  logic [NREQ-1:0][1:0]           w_ops;
  logic [NREQ-1:0][WIDTH-1:0]     w_masks;

  assign w_ops   = req_op;
  assign w_masks = req_mask;

  // Scan offsets from far to near so the requester closest to the pointer
  // is the last (winning) assignment.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_sum = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_ptr} + (IDXW+1)'(k);
      if (w_sum >= (IDXW+1)'(NREQ)) w_sum = w_sum - (IDXW+1)'(NREQ);
      if (req_valid[w_sum[IDXW-1:0]]) begin
        w_any = 1'b1;
        w_win = w_sum[IDXW-1:0];
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = APPLY;
      APPLY:   w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
      r_op    <= OP_HOLD;
      r_mask  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_any) begin
        r_grant <= w_win;
        r_op    <= w_ops[w_win];
        r_mask  <= w_masks[w_win];
      end
      if (r_state == DONE) begin
        r_ptr <= (r_grant == IDXW'(NREQ - 1)) ? '0 : r_grant + 1'b1;
      end
    end
  end

  always_comb begin
    req_ack = '0;
    if (r_state == DONE) req_ack[r_grant] = 1'b1;
  end

  assign busy      = (r_state != IDLE);
  assign grant_idx = r_grant;
  assign w_jk      = op_to_jk(r_op);
  assign w_en      = (r_state == APPLY) ? r_mask : '0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .en  (w_en[i]),
      .J   (w_jk[1]),
      .K   (w_jk[0]),
      .Q   (q[i])
    );
  end

endmodule
